// File: rtl/do_xung_pkg.sv
// Shared definitions for the pump pulse-train receiver: FSM encoding and
// default widths/limits, plus the generator frame shape it is expected to see.
package do_xung_pkg;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_RISE = 2'd1,
    S_HIGH      = 2'd2,
    S_LOW       = 2'd3
  } state_e;

  localparam int unsigned CW_DEFAULT      = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 1000;
  localparam int unsigned SYNC_DEFAULT    = 2;

  // Generator frame: FRAME_LEN+1 counts per frame, FRAME_HIGH of them high.
  localparam int unsigned FRAME_LEN  = 100;
  localparam int unsigned FRAME_HIGH = 50;

endpackage

// File: rtl/do_xung_dong_bo_canh.sv
// Multi-stage synchronizer with rise/fall detection for an asynchronous level input.
// ready marks the point after reset where level reflects a real sample of the input.
module dong_bo_canh #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_async,
  output logic level,
  output logic rise,
  output logic fall,
  output logic ready
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [SYNC_STAGES-1:0] rdy_q, rdy_d;
  logic                   level_prev_q, level_prev_d;

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], in_async};
    rdy_d        = {rdy_q[SYNC_STAGES-2:0], 1'b1};
    level_prev_d = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q       <= '0;
      rdy_q        <= '0;
      level_prev_q <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      rdy_q        <= rdy_d;
      level_prev_q <= level_prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_prev_q;
  assign fall  = ~level & level_prev_q;
  assign ready = rdy_q[SYNC_STAGES-1];

endmodule

// File: rtl/do_xung.sv
// Measures period and high time of the pump drive waveform, flags duty above 50%
// and declares a stall when no qualifying edge arrives within TIMEOUT cycles.
module do_xung
  import do_xung_pkg::*;
#(
  parameter int unsigned CW          = CW_DEFAULT,
  parameter int unsigned TIMEOUT     = TIMEOUT_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          xung_in,
  output logic [CW-1:0] period,
  output logic [CW-1:0] high_time,
  output logic          valid,
  output logic          bom_on,
  output logic          stall,
  output logic          level
);

  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  logic rise, fall, ready;

  dong_bo_canh #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_dong_bo_canh (
    .clk     (clk),
    .rst     (rst),
    .in_async(xung_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall),
    .ready   (ready)
  );

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_p_q, cnt_p_d;
  logic [CW-1:0] cnt_h_q, cnt_h_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] high_time_q, high_time_d;
  logic          valid_q, valid_d;
  logic          bom_on_q, bom_on_d;
  logic          stall_q, stall_d;
  logic [CW-1:0] cnt_p_inc;
  logic          timed_out;

  assign cnt_p_inc = (cnt_p_q == CNT_MAX) ? cnt_p_q : cnt_p_q + 1'b1;
  assign timed_out = (cnt_p_q >= TIMEOUT_C);

  always_comb begin
    state_d     = state_q;
    cnt_p_d     = cnt_p_q;
    cnt_h_d     = cnt_h_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    bom_on_d    = bom_on_q;
    stall_d     = stall_q;

    case (state_q)
      // Leaving idle only on a genuine low level discards a partial first high phase.
      S_IDLE: begin
        if (ready && !level) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (rise) begin
          cnt_p_d = CNT_ONE;
          cnt_h_d = CNT_ONE;
          stall_d = 1'b0;
          state_d = S_HIGH;
        end
      end
      S_HIGH: begin
        if (fall) begin
          cnt_h_d = cnt_p_q;
          cnt_p_d = cnt_p_inc;
          state_d = S_LOW;
        end else if (timed_out) begin
          stall_d  = 1'b1;
          bom_on_d = 1'b0;
          cnt_p_d  = '0;
          state_d  = S_WAIT_RISE;
        end else begin
          cnt_p_d = cnt_p_inc;
        end
      end
      S_LOW: begin
        if (rise) begin
          period_d    = cnt_p_q;
          high_time_d = cnt_h_q;
          bom_on_d    = {cnt_h_q, 1'b0} > {1'b0, cnt_p_q};
          valid_d     = 1'b1;
          cnt_p_d     = CNT_ONE;
          cnt_h_d     = CNT_ONE;
          stall_d     = 1'b0;
          state_d     = S_HIGH;
        end else if (timed_out) begin
          stall_d  = 1'b1;
          bom_on_d = 1'b0;
          cnt_p_d  = '0;
          state_d  = S_WAIT_RISE;
        end else begin
          cnt_p_d = cnt_p_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_p_q     <= '0;
      cnt_h_q     <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      bom_on_q    <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_p_q     <= cnt_p_d;
      cnt_h_q     <= cnt_h_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      bom_on_q    <= bom_on_d;
      stall_q     <= stall_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_time_q;
  assign valid     = valid_q;
  assign bom_on    = bom_on_q;
  assign stall     = stall_q;

endmodule

// File: tb/tb_do_xung.sv
// Bench for do_xung: directed and random pulse trains checked every cycle against
// a timestamp-based reference model of the measured waveform.
module tb_do_xung;
  import do_xung_pkg::*;

  localparam int CW = 16;
  localparam int TO = 200;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          xung_in;
  logic [CW-1:0] period, high_time;
  logic          valid, bom_on, stall, level;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: input history since reset plus timestamps of detected edges.
  bit            hist[$];
  bit            m_armed, m_meas, m_have_fall;
  int            m_rise_t, m_fall_t;
  logic [CW-1:0] e_period, e_high;
  logic          e_valid, e_bom, e_stall, e_level;

  always #5 clk = ~clk;

  do_xung #(
    .CW(CW),
    .TIMEOUT(TO),
    .SYNC_STAGES(SS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .xung_in  (xung_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .bom_on   (bom_on),
    .stall    (stall),
    .level    (level)
  );

  task automatic check1(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkOutput();
    check1("period", 32'(period), 32'(e_period));
    check1("high_time", 32'(high_time), 32'(e_high));
    check1("valid", 32'(valid), 32'(e_valid));
    check1("bom_on", 32'(bom_on), 32'(e_bom));
    check1("stall", 32'(stall), 32'(e_stall));
    check1("level", 32'(level), 32'(e_level));
  endtask

  // Predicts outputs after the coming clock edge from the inputs now applied.
  // The detected line is the input delayed by SS cycles.
  task automatic modelStep();
    int n, per, hi;
    bit lvl, lvd, r, f;
    if (rst) begin
      hist.delete();
      m_armed = 0; m_meas = 0; m_have_fall = 0;
      e_period = '0; e_high = '0; e_valid = 0; e_bom = 0; e_stall = 0; e_level = 0;
    end else begin
      hist.push_back(xung_in);
      n   = hist.size() - 1;
      lvl = (n >= SS)     ? hist[n-SS]   : 1'b0;
      lvd = (n >= SS + 1) ? hist[n-SS-1] : 1'b0;
      r   = lvl & !lvd;
      f   = !lvl & lvd;
      e_level = (n - SS + 1 >= 0) ? hist[n-SS+1] : 1'b0;
      e_valid = 0;
      if (!m_armed) begin
        if (n >= SS && !lvl) m_armed = 1;
      end else if (r) begin
        if (m_meas && m_have_fall) begin
          per      = n - m_rise_t;
          hi       = m_fall_t - m_rise_t;
          e_period = per[CW-1:0];
          e_high   = hi[CW-1:0];
          e_bom    = (2 * hi > per);
          e_valid  = 1;
        end
        e_stall     = 0;
        m_meas      = 1;
        m_rise_t    = n;
        m_have_fall = 0;
      end else if (f && m_meas && !m_have_fall) begin
        m_fall_t    = n;
        m_have_fall = 1;
      end else if (m_meas && (n - m_rise_t) >= TO) begin
        e_stall = 1;
        e_bom   = 0;
        m_meas  = 0;
      end
    end
  endtask

  task automatic applyStimulus(input bit val, input bit rst_val, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      checkOutput();
      rst     = rst_val;
      xung_in = val;
      modelStep();
    end
  endtask

  task automatic frames(input int hi, input int lo, input int count);
    for (int k = 0; k < count; k++) begin
      applyStimulus(1'b1, 1'b0, hi);
      applyStimulus(1'b0, 1'b0, lo);
    end
  endtask

  initial begin
    int hi, lo;
    rst     = 1'b1;
    xung_in = 1'b0;
    modelStep();
    applyStimulus(1'b0, 1'b1, 3);
    check1("reset_period", 32'(period), 0);
    check1("reset_valid", 32'(valid), 0);

    $display("[TB] 3 high / 5 low");
    applyStimulus(1'b0, 1'b0, 4);
    frames(3, 5, 6);
    check1("p8_period", 32'(period), 8);
    check1("p8_high", 32'(high_time), 3);
    check1("p8_bom", 32'(bom_on), 0);

    $display("[TB] generator frames");
    frames(FRAME_HIGH, FRAME_LEN - FRAME_HIGH + 1, 3);
    check1("gen_period", 32'(period), 101);
    check1("gen_high", 32'(high_time), 50);
    check1("gen_bom", 32'(bom_on), 0);
    frames(60, 41, 3);
    check1("gen60_period", 32'(period), 101);
    check1("gen60_high", 32'(high_time), 60);
    check1("gen60_bom", 32'(bom_on), 1);

    $display("[TB] stall while held high");
    applyStimulus(1'b1, 1'b0, TO + 10);
    check1("stall_set", 32'(stall), 1);
    check1("stall_bom", 32'(bom_on), 0);
    check1("stall_level", 32'(level), 1);
    check1("stall_period", 32'(period), 101);
    applyStimulus(1'b0, 1'b0, 20);
    frames(5, 5, 2);
    check1("unstall", 32'(stall), 0);
    check1("unstall_period", 32'(period), 10);
    check1("unstall_high", 32'(high_time), 5);

    $display("[TB] high during reset release");
    applyStimulus(1'b1, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 30);
    check1("partial_valid", 32'(valid), 0);
    check1("partial_period", 32'(period), 0);
    applyStimulus(1'b0, 1'b0, 10);
    frames(4, 6, 3);
    check1("partial_after", 32'(period), 10);
    check1("partial_after_high", 32'(high_time), 4);

    $display("[TB] reset pulse in low phase");
    frames(8, 12, 3);
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 6);
    applyStimulus(1'b0, 1'b1, 1);
    applyStimulus(1'b0, 1'b0, 1);
    check1("rstpulse_period", 32'(period), 0);
    check1("rstpulse_valid", 32'(valid), 0);
    frames(8, 12, 3);
    check1("rstpulse_restart", 32'(period), 20);

    $display("[TB] 1/1 toggle");
    frames(1, 1, 12);
    check1("tog_period", 32'(period), 2);
    check1("tog_high", 32'(high_time), 1);

    $display("[TB] random frames");
    for (int k = 0; k < 30; k++) begin
      hi = $urandom_range(1, 40);
      lo = $urandom_range(1, 40);
      frames(hi, lo, 1);
      if (k % 8 == 7) applyStimulus(1'b0, 1'b0, TO + $urandom_range(0, 20));
    end
    applyStimulus(1'b0, 1'b0, 10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
